// File: rtl/bam8_dot_acc.sv
// Streaming dot-product stage: 8x8 broken-array approximate multiplier (hbreak 5,
// vbreak 9) feeding a LEN-deep accumulator with valid/ready in and out.
module bam8_dot_acc #(
  parameter int LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_a,
  input  logic [7:0]                  in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [16+$clog2(LEN)-1:0]   out_sum,
  output logic                        busy
);

  localparam int ACC_W = 16 + $clog2(LEN);
  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {ACC, ACC_PEND} state_t;

  state_t             state, state_nxt;
  logic [15:0]        p_reg;
  logic               p_vld;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               grp_done;

  // Only rows 5..7 survive, and within them only columns with weight 2^9 or more.
  function automatic logic [15:0] approx_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] s;
    s = '0;
    for (int j = 5; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i + j) >= 9 && a[i] && b[j])
          s = s + (16'(1) << (i + j));
      end
    end
    return s;
  endfunction

  assign out_valid = (state == ACC_PEND);
  assign in_ready  = !(out_valid && !out_ready) && !clr;
  assign accept    = in_valid && in_ready;
  assign grp_done  = p_vld && !clr && (cnt == LAST);
  assign busy      = (cnt != '0) || p_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ACC;
    else
      state <= state_nxt;
  end

  // A completing group reloads the output register and wins over a same-cycle drain.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:      if (grp_done) state_nxt = ACC_PEND;
      ACC_PEND: if (grp_done) state_nxt = ACC_PEND;
                else if (out_ready) state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      p_vld   <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
    end else begin
      p_vld <= accept;
      if (accept)
        p_reg <= approx_mul(in_a, in_b);
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (p_vld) begin
        if (cnt == LAST) begin
          out_sum <= acc + ACC_W'(p_reg);
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= acc + ACC_W'(p_reg);
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bam8_dot_acc.sv
// Self-checking bench for bam8_dot_acc: directed scenarios plus a random
// scoreboard run against an independent model of the approximate product.
module tb_bam8_dot_acc;

  localparam int LEN   = 8;
  localparam int ACC_W = 19;

  logic             clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]       in_a, in_b;
  logic [ACC_W-1:0] out_sum;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int exp_q[$];
  int m_acc, m_cnt, m_pp;
  bit m_pv;

  bam8_dot_acc #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: truncate a below column 9-j for each kept row j.
  function automatic int ref_p(input int a, input int b);
    int s = 0;
    for (int j = 5; j < 8; j++)
      if (b[j]) s += ((a >> (9 - j)) << (9 - j)) << j;
    return s;
  endfunction

  // Scoreboard model: push expected sums on group completion, pop on handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0; m_cnt = 0; m_pv = 0; m_pp = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected got %0d expected none", out_sum);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (out_sum !== ACC_W'(e)) begin
            errors++;
            $display("[TB] FAIL sb_sum got %0d expected %0d", out_sum, e);
          end
        end
      end
      if (clr) begin
        m_acc = 0; m_cnt = 0;
      end else if (m_pv) begin
        if (m_cnt == LEN - 1) begin
          exp_q.push_back(m_acc + m_pp);
          m_acc = 0; m_cnt = 0;
        end else begin
          m_acc += m_pp; m_cnt++;
        end
      end
      m_pv = in_valid && in_ready && !clr;
      m_pp = ref_p(int'(in_a), int'(in_b));
      if (m_pv) n_acc++;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int k = 0; k < 500 && !done; k++) begin
      #1;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout got in_ready=0 expected 1");
    end
  endtask

  task automatic send_n(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < n; k++) send(a, b);
  endtask

  task automatic wait_out(input int exp, input string name);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL %s_timeout got out_valid=0 expected 1", name);
    end else if (out_sum !== ACC_W'(exp)) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, out_sum, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s got ov=%b sum=%0d busy=%b rdy=%b expected 0 0 0 1",
               name, out_valid, out_sum, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    check_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset_release");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_n(LEN, 8'd255, 8'd255);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL latency_t1 got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== ACC_W'(446464)) begin
      errors++; $display("[TB] FAIL latency_t2 got ov=%b sum=%0d expected 1 446464", out_valid, out_sum);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pulse got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_patterns();
    out_ready = 1'b1;
    send_n(4, 8'd128, 8'd128);
    send_n(4, 8'd8, 8'd32);
    wait_out(65536, "mix_sum");
    @(negedge clk);
    send_n(LEN, 8'd16, 8'd32);
    wait_out(4096, "small_sum");
    @(negedge clk);
    send_n(LEN - 1, 8'd16, 8'd32);
    send(8'd255, 8'd31);
    wait_out(3584, "low_b_zero");
    @(negedge clk);
  endtask

  task automatic test_stall();
    int acc0, hold_sum, acc_stall;
    acc0 = n_acc;
    out_ready = 1'b0;
    fork
      send_n(2 * LEN, 8'd255, 8'd128);
      begin
        wait_out(258048, "stall_first");
        hold_sum  = int'(out_sum);
        acc_stall = n_acc;
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== ACC_W'(hold_sum)) begin
            errors++;
            $display("[TB] FAIL stall_hold got rdy=%b ov=%b sum=%0d expected 0 1 %0d",
                     in_ready, out_valid, out_sum, hold_sum);
          end
          @(negedge clk);
        end
        checks++;
        if (n_acc !== acc_stall) begin
          errors++; $display("[TB] FAIL stall_no_accept got %0d expected %0d", n_acc, acc_stall);
        end
        out_ready = 1'b1;
        @(negedge clk);
        wait_out(258048, "stall_second");
      end
    join
    @(negedge clk);
    checks++;
    if (n_acc - acc0 !== 2 * LEN) begin
      errors++; $display("[TB] FAIL stall_count got %0d expected %0d", n_acc - acc0, 2 * LEN);
    end
  endtask

  task automatic test_clr();
    int acc0;
    out_ready = 1'b1;
    send_n(3, 8'd255, 8'd255);
    acc0 = n_acc;
    clr = 1'b1; in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_ready got %b expected 0", in_ready);
    end
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || n_acc !== acc0) begin
      errors++; $display("[TB] FAIL clr_busy got busy=%b acc=%0d expected 0 %0d", busy, n_acc, acc0);
    end
    send_n(LEN, 8'd128, 8'd128);
    wait_out(131072, "clr_sum");
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send_n(4, 8'd200, 8'd200);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid_group");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    send_n(LEN, 8'd255, 8'd255);
    wait_out(446464, "pending_before_rst");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_pending");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_n(LEN, 8'd128, 8'd128);
    wait_out(131072, "post_rst_sum");
    @(negedge clk);
  endtask

  task automatic test_random();
    int acc0, out0;
    bit stopped = 0;
    acc0 = n_acc; out0 = n_out;
    for (int k = 0; k < 60000 && !stopped; k++) begin
      if (n_acc - acc0 >= 1000 * LEN) begin
        stopped = 1;
        in_valid = 1'b0;
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_a      = 8'($urandom_range(0, 255));
        in_b      = 8'($urandom_range(0, 255));
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 100 && (n_out - out0) < 1000; k++) @(negedge clk);
    checks++;
    if (n_out - out0 !== 1000 || n_acc - acc0 !== 1000 * LEN || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_groups got out=%0d pairs=%0d left=%0d expected 1000 %0d 0",
               n_out - out0, n_acc - acc0, exp_q.size(), 1000 * LEN);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_patterns();
    test_stall();
    test_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
